// File: rtl/pc_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// pc_fetch_ctrl
// Fetch-stage controller for the pipelined RISC-V core.
// Owns the fetch PC and the fetch/decode pipeline register, runs the
// req/ready handshake to instruction memory, and sequences the PC through
// reset, sequential fetch, hazard stalls, branch/jump redirects and traps.
//
// Timing notes:
//  - Every output is driven straight from a flop.
//  - o_imem_addr is always the current fetch PC with bits [1:0] forced low.
//    Because a redirect/trap that arrives while IMEM is busy is parked in
//    r_pend_pc (and the machine moves to DRAIN), the fetch PC, and therefore
//    the address, stays stable until IMEM accepts it.
//  - o_misalign_err is a single-cycle pulse, registered: it is visible in
//    the cycle after the misaligned redirect was presented.
// ----------------------------------------------------------------------------
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_stall_f,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_trap_valid,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_pc_f,
    output logic        o_instr_valid_d,
    output logic [31:0] o_instr_d,
    output logic [31:0] o_pc_d,
    output logic [31:0] o_pcplus4_d,
    output logic        o_misalign_err
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,  // one dead cycle after reset, no request
        ST_FETCH = 2'd1,  // normal fetching at r_pc_f
        ST_DRAIN = 2'd2   // waiting out an in-flight fetch before jumping
    } state_t;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------

    // A redirect target is usable only when it is word aligned.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    // Select the control-flow target: trap beats redirect, and a misaligned
    // redirect is turned into a trap entry.
    function automatic logic [31:0] pick_target(
        input logic        trap,
        input logic [31:0] redir_pc
    );
        logic [31:0] tgt;
        if (trap) begin
            tgt = TRAP_VECTOR;
        end else if (is_misaligned(redir_pc)) begin
            tgt = TRAP_VECTOR;
        end else begin
            tgt = redir_pc;
        end
        return tgt;
    endfunction

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t      r_state;
    logic [31:0] r_pc_f;
    logic [31:0] r_pend_pc;
    logic        r_imem_req;
    logic        r_instr_valid_d;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [31:0] r_pcplus4_d;
    logic        r_misalign_err;

    // ------------------------------------------------------------------------
    // Combinational decode of the control-flow inputs
    // ------------------------------------------------------------------------
    logic        w_event;          // trap or redirect requested this cycle
    logic        w_misalign_hit;   // winning event is a misaligned redirect
    logic [31:0] w_target;         // PC to jump to if w_event
    logic [31:0] w_pc_next_seq;    // sequential successor of the fetch PC

    // Classify this cycle's trap/redirect request and compute its target.
    always_comb begin
        w_event        = 1'b0;
        w_misalign_hit = 1'b0;
        w_target       = TRAP_VECTOR;
        w_pc_next_seq  = r_pc_f + 32'd4;
        if (i_trap_valid || i_redirect_valid) begin
            w_event  = 1'b1;
            w_target = pick_target(i_trap_valid, i_redirect_pc);
            if (!i_trap_valid && is_misaligned(i_redirect_pc)) begin
                w_misalign_hit = 1'b1;
            end else begin
                w_misalign_hit = 1'b0;
            end
        end else begin
            w_event        = 1'b0;
            w_misalign_hit = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Fetch sequencer: PC, pending target, IMEM request and decode register
    // ------------------------------------------------------------------------

    // Single FSM advancing the fetch PC and filling the decode register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_BOOT;
            r_pc_f          <= RESET_VECTOR;
            r_pend_pc       <= 32'h0000_0000;
            r_imem_req      <= 1'b0;
            r_instr_valid_d <= 1'b0;
            r_instr_d       <= NOP_INSTR;
            r_pc_d          <= 32'h0000_0000;
            r_pcplus4_d     <= 32'h0000_0004;
            r_misalign_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    // Control-flow and stall inputs are ignored while booting.
                    r_state        <= ST_FETCH;
                    r_imem_req     <= 1'b1;
                    r_misalign_err <= 1'b0;
                end

                ST_FETCH: begin
                    r_imem_req     <= 1'b1;
                    r_misalign_err <= w_misalign_hit;
                    if (w_event) begin
                        // Anything already fetched is on the wrong path.
                        r_instr_valid_d <= 1'b0;
                        r_instr_d       <= NOP_INSTR;
                        if (i_imem_ready) begin
                            r_pc_f <= w_target;
                        end else begin
                            // IMEM still owns the current address: finish
                            // that beat first, then jump.
                            r_pend_pc <= w_target;
                            r_state   <= ST_DRAIN;
                        end
                    end else if (i_stall_f) begin
                        // Hold PC and decode register; the same address is
                        // re-presented next cycle.
                        r_pc_f <= r_pc_f;
                    end else if (i_imem_ready) begin
                        r_instr_valid_d <= 1'b1;
                        r_instr_d       <= i_imem_rdata;
                        r_pc_d          <= r_pc_f;
                        r_pcplus4_d     <= w_pc_next_seq;
                        r_pc_f          <= w_pc_next_seq;
                    end else begin
                        // IMEM wait state: push a bubble into decode.
                        r_instr_valid_d <= 1'b0;
                        r_instr_d       <= NOP_INSTR;
                    end
                end

                ST_DRAIN: begin
                    r_imem_req      <= 1'b1;
                    r_misalign_err  <= w_misalign_hit;
                    r_instr_valid_d <= 1'b0;
                    r_instr_d       <= NOP_INSTR;
                    if (i_imem_ready) begin
                        // Returned data belongs to the abandoned path.
                        if (w_event) begin
                            r_pc_f <= w_target;
                        end else begin
                            r_pc_f <= r_pend_pc;
                        end
                        r_state <= ST_FETCH;
                    end else if (w_event) begin
                        // Latest request wins.
                        r_pend_pc <= w_target;
                    end else begin
                        r_pend_pc <= r_pend_pc;
                    end
                end

                default: begin
                    r_state         <= ST_BOOT;
                    r_imem_req      <= 1'b0;
                    r_instr_valid_d <= 1'b0;
                    r_instr_d       <= NOP_INSTR;
                    r_misalign_err  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping (all outputs come directly from flops)
    // ------------------------------------------------------------------------
    assign o_imem_req      = r_imem_req;
    assign o_imem_addr     = {r_pc_f[31:2], 2'b00};
    assign o_pc_f          = r_pc_f;
    assign o_instr_valid_d = r_instr_valid_d;
    assign o_instr_d       = r_instr_d;
    assign o_pc_d          = r_pc_d;
    assign o_pcplus4_d     = r_pcplus4_d;
    assign o_misalign_err  = r_misalign_err;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pc_fetch_ctrl
// Scoreboard bench for pc_fetch_ctrl. The stimulus process pushes the
// hand-computed per-cycle expectation for every cycle in which the DUT
// drives a fetch request; monitor processes pop and compare whenever the
// DUT presents imem_req. A second instance with RESET_VECTOR=FFFF_FFF8
// covers PC wrap-around.
// ----------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

    typedef struct packed {
        logic [31:0] addr;
        logic        vld;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic [31:0] p4;
        logic        mis;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reset2 = 1'b1;
    logic        stall = 1'b0;
    logic        rv = 1'b0;
    logic [31:0] rpc = 32'h0;
    logic        trap = 1'b0;
    logic        ready = 1'b1;

    logic        req1, vld1, mis1;
    logic [31:0] addr1, rdata1, pcf1, instr1, pcd1, p41;
    logic        req2, vld2, mis2;
    logic [31:0] addr2, rdata2, pcf2, instr2, pcd2, p42;

    int total = 0;
    int bad   = 0;
    rec_t q1[$];
    rec_t q2[$];

    // Simple IMEM: data is a tag plus the low half of the address.
    assign rdata1 = {16'hC0DE, addr1[15:0]};
    assign rdata2 = {16'hC0DE, addr2[15:0]};

    always #5 clk = ~clk;

    pc_fetch_ctrl dut (
        .clk(clk), .reset(reset),
        .i_stall_f(stall), .i_redirect_valid(rv), .i_redirect_pc(rpc),
        .i_trap_valid(trap),
        .o_imem_req(req1), .o_imem_addr(addr1),
        .i_imem_ready(ready), .i_imem_rdata(rdata1),
        .o_pc_f(pcf1), .o_instr_valid_d(vld1), .o_instr_d(instr1),
        .o_pc_d(pcd1), .o_pcplus4_d(p41), .o_misalign_err(mis1)
    );

    pc_fetch_ctrl #(.RESET_VECTOR(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .reset(reset2),
        .i_stall_f(1'b0), .i_redirect_valid(1'b0), .i_redirect_pc(32'h0),
        .i_trap_valid(1'b0),
        .o_imem_req(req2), .o_imem_addr(addr2),
        .i_imem_ready(1'b1), .i_imem_rdata(rdata2),
        .o_pc_f(pcf2), .o_instr_valid_d(vld2), .o_instr_d(instr2),
        .o_pc_d(pcd2), .o_pcplus4_d(p42), .o_misalign_err(mis2)
    );

    task automatic chk(input string nm, input rec_t got, input rec_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got addr=%h vld=%b instr=%h pcd=%h p4=%h mis=%b / exp addr=%h vld=%b instr=%h pcd=%h p4=%h mis=%b",
                     nm, got.addr, got.vld, got.instr, got.pcd, got.p4, got.mis,
                     exp.addr, exp.vld, exp.instr, exp.pcd, exp.p4, exp.mis);
        end
    endtask

    task automatic exp1(input logic [31:0] a, input logic v, input logic [31:0] ins,
                        input logic [31:0] pd, input logic [31:0] p4, input logic m);
        q1.push_back({a, v, ins, pd, p4, m});
    endtask

    task automatic exp2(input logic [31:0] a, input logic v, input logic [31:0] ins,
                        input logic [31:0] pd, input logic [31:0] p4, input logic m);
        q2.push_back({a, v, ins, pd, p4, m});
    endtask

    // Apply one cycle of inputs, then step past the rising edge.
    task automatic drive(input logic st, input logic rv_i, input logic [31:0] rpc_i,
                         input logic tr, input logic rdy);
        stall = st; rv = rv_i; rpc = rpc_i; trap = tr; ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Monitor for the main instance.
    always @(negedge clk) begin
        if (!reset && req1) begin
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut1_unexpected got addr=%h exp no request", addr1);
            end else begin
                chk("dut1", {addr1, vld1, instr1, pcd1, p41, mis1}, q1.pop_front());
            end
        end
    end

    // Monitor for the wrap-around instance; only active while expectations remain.
    always @(negedge clk) begin
        if (!reset2 && req2 && q2.size() != 0) begin
            chk("dut2", {addr2, vld2, instr2, pcd2, p42, mis2}, q2.pop_front());
        end
    end

    initial begin
        // Reset state
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        total++;
        if (req1 !== 1'b0) begin
            bad++;
            $display("FAIL reset_req got=%b exp=0", req1);
        end
        chk("reset", {pcf1, vld1, instr1, pcd1, p41, mis1},
            {32'h0, 1'b0, 32'h13, 32'h0, 32'h4, 1'b0});

        // C0: BOOT dead cycle, no request expected
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        // Sequential fetch with zero-wait IMEM
        exp1(32'h0,   1'b0, 32'h13,        32'h0,   32'h4,   1'b0); drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        exp1(32'h4,   1'b1, 32'hC0DE_0000, 32'h0,   32'h4,   1'b0); drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        // IMEM wait two cycles at address 8
        exp1(32'h8,   1'b1, 32'hC0DE_0004, 32'h4,   32'h8,   1'b0); drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        exp1(32'h8,   1'b0, 32'h13,        32'h4,   32'h8,   1'b0); drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        exp1(32'h8,   1'b0, 32'h13,        32'h4,   32'h8,   1'b0); drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        exp1(32'hC,   1'b1, 32'hC0DE_0008, 32'h8,   32'hC,   1'b0); drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        // Redirect to 0x200 at address 0x10 with ready
        exp1(32'h10,  1'b1, 32'hC0DE_000C, 32'hC,   32'h10,  1'b0); drive(1'b0, 1'b1, 32'h200, 1'b0, 1'b1);
        exp1(32'h200, 1'b0, 32'h13,        32'hC,   32'h10,  1'b0); drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        // Redirect to 0x300 while IMEM busy at 0x204 -> DRAIN
        exp1(32'h204, 1'b1, 32'hC0DE_0200, 32'h200, 32'h204, 1'b0); drive(1'b0, 1'b1, 32'h300, 1'b0, 1'b0);
        exp1(32'h204, 1'b0, 32'h13,        32'h200, 32'h204, 1'b0); drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        exp1(32'h204, 1'b0, 32'h13,        32'h200, 32'h204, 1'b0); drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        // Trap and redirect together -> trap vector
        exp1(32'h300, 1'b0, 32'h13,        32'h200, 32'h204, 1'b0); drive(1'b0, 1'b1, 32'h40, 1'b1, 1'b1);
        // Misaligned redirect -> trap vector plus error pulse
        exp1(32'h100, 1'b0, 32'h13,        32'h200, 32'h204, 1'b0); drive(1'b0, 1'b1, 32'h42, 1'b0, 1'b1);
        exp1(32'h100, 1'b0, 32'h13,        32'h200, 32'h204, 1'b1); drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        // Stall three cycles
        exp1(32'h104, 1'b1, 32'hC0DE_0100, 32'h100, 32'h104, 1'b0); drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        exp1(32'h104, 1'b1, 32'hC0DE_0100, 32'h100, 32'h104, 1'b0); drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        exp1(32'h104, 1'b1, 32'hC0DE_0100, 32'h100, 32'h104, 1'b0); drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        exp1(32'h104, 1'b1, 32'hC0DE_0100, 32'h100, 32'h104, 1'b0); drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        // Trap while busy, then a redirect in DRAIN overrides it; stall ignored in DRAIN
        exp1(32'h108, 1'b1, 32'hC0DE_0104, 32'h104, 32'h108, 1'b0); drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        exp1(32'h108, 1'b0, 32'h13,        32'h104, 32'h108, 1'b0); drive(1'b0, 1'b1, 32'h500, 1'b0, 1'b0);
        exp1(32'h108, 1'b0, 32'h13,        32'h104, 32'h108, 1'b0); drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        // Enter DRAIN again, then reset mid-DRAIN drops the pending target
        exp1(32'h500, 1'b0, 32'h13,        32'h104, 32'h108, 1'b0); drive(1'b0, 1'b1, 32'h600, 1'b0, 1'b0);
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        reset = 1'b0;
        // BOOT: misaligned redirect is ignored, no error pulse
        drive(1'b0, 1'b1, 32'h42, 1'b0, 1'b1);
        exp1(32'h0,   1'b0, 32'h13,        32'h0,   32'h4,   1'b0); drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        exp1(32'h4,   1'b1, 32'hC0DE_0000, 32'h0,   32'h4,   1'b0); drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        total++;
        if (q1.size() != 0) begin
            bad++;
            $display("FAIL dut1_leftover got=%0d pending exp=0", q1.size());
        end

        // Wrap-around instance
        exp2(32'hFFFF_FFF8, 1'b0, 32'h13,        32'h0,         32'h4,         1'b0);
        exp2(32'hFFFF_FFFC, 1'b1, 32'hC0DE_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 1'b0);
        exp2(32'h0000_0000, 1'b1, 32'hC0DE_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0);
        exp2(32'h0000_0004, 1'b1, 32'hC0DE_0000, 32'h0000_0000, 32'h0000_0004, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        reset2 = 1'b0;
        for (int i = 0; i < 20 && q2.size() != 0; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        end
        total++;
        if (q2.size() != 0) begin
            bad++;
            $display("FAIL dut2_timeout got=%0d pending exp=0", q2.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
